// File: rtl/rv64g_l2_arrays_pkg.sv
// Shared geometry for the L2 data/tag arrays: set/way/line dimensions and derived field widths.
package rv64g_l2_pkg;

    localparam int NUM_WAYS       = 16;
    localparam int NUM_SETS       = 256;
    localparam int WORDS_PER_LINE = 8;
    localparam int TAG_W          = 50;
    localparam int DATA_W         = 64;

    localparam int INDEX_W = $clog2(NUM_SETS);
    localparam int WORD_W  = $clog2(WORDS_PER_LINE);
    localparam int WAY_W   = $clog2(NUM_WAYS);
    localparam int BE_W    = DATA_W / 8;

endpackage

// File: rtl/rv64g_l2_arrays_way_bank.sv
// One way of the L2: byte-enabled data storage plus tag storage, both read combinationally.
// Tag reset-to-zero is enabled by RV64G_L2_ARRAYS_TAG_CLR_EN; the data storage is never reset.
module rv64g_l2_way_bank
    import rv64g_l2_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] index_i,
    input  logic [WORD_W-1:0]  word_sel_i,
    input  logic               write_en_i,
    input  logic [BE_W-1:0]    be_i,
    input  logic [TAG_W-1:0]   tag_in_i,
    input  logic [DATA_W-1:0]  wdata_i,
    output logic [DATA_W-1:0]  rdata_o,
    output logic [TAG_W-1:0]   tag_o
);

    logic [DATA_W-1:0] data_mem [NUM_SETS*WORDS_PER_LINE];
    logic [TAG_W-1:0]  tag_mem  [NUM_SETS];

    logic [INDEX_W+WORD_W-1:0] data_addr;
    logic                      do_write;

    assign data_addr = {index_i, word_sel_i};
    // Writes are suppressed while reset is held, even though the arrays themselves are not reset.
    assign do_write  = write_en_i & rst_n;

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int k = 0; k < BE_W; k++) begin
                if (be_i[k]) begin
                    data_mem[data_addr][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

`ifdef RV64G_L2_ARRAYS_TAG_CLR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                tag_mem[s] <= '0;
            end
        end else if (write_en_i) begin
            tag_mem[index_i] <= tag_in_i;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (do_write) begin
            tag_mem[index_i] <= tag_in_i;
        end
    end
`endif

    assign rdata_o = data_mem[data_addr];
    assign tag_o   = tag_mem[index_i];

endmodule

// File: rtl/rv64g_l2_arrays.sv
// L2 data and tag arrays: one way bank per way, combinational all-way and selected-way reads.
// Optional tag clear on reset via RV64G_L2_ARRAYS_TAG_CLR_EN.
module rv64g_l2_arrays
    import rv64g_l2_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [INDEX_W-1:0]         index_i,
    input  logic [WORD_W-1:0]          word_sel_i,
    input  logic [WAY_W-1:0]           way_sel_i,
    input  logic                       write_en_i,
    input  logic [BE_W-1:0]            be_i,
    input  logic [TAG_W-1:0]           tag_in_i,
    input  logic [DATA_W-1:0]          wdata_i,
    output logic [DATA_W-1:0]          rdata_selected_o,
    output logic [TAG_W-1:0]           tag_selected_o,
    output logic [NUM_WAYS*DATA_W-1:0] rdata_way_flat_o,
    output logic [NUM_WAYS*TAG_W-1:0]  tag_way_flat_o
);

    logic [DATA_W-1:0] rdata_way [NUM_WAYS];
    logic [TAG_W-1:0]  tag_way   [NUM_WAYS];

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        logic way_we;

        assign way_we = write_en_i && (way_sel_i == WAY_W'(w));

        rv64g_l2_way_bank u_bank (
            .clk        (clk),
            .rst_n      (rst_n),
            .index_i    (index_i),
            .word_sel_i (word_sel_i),
            .write_en_i (way_we),
            .be_i       (be_i),
            .tag_in_i   (tag_in_i),
            .wdata_i    (wdata_i),
            .rdata_o    (rdata_way[w]),
            .tag_o      (tag_way[w])
        );

        assign rdata_way_flat_o[w*DATA_W +: DATA_W] = rdata_way[w];
        assign tag_way_flat_o[w*TAG_W +: TAG_W]     = tag_way[w];
    end

    assign rdata_selected_o = rdata_way[way_sel_i];
    assign tag_selected_o   = tag_way[way_sel_i];

endmodule

// File: tb/tb_rv64g_l2_arrays.sv
// Scoreboard bench for rv64g_l2_arrays: a shadow model predicts reads, expectations are queued
// when a read is driven and compared once the combinational outputs settle.
module tb_rv64g_l2_arrays;

    logic          clk;
    logic          rst_n;
    logic [7:0]    index_i;
    logic [2:0]    word_sel_i;
    logic [3:0]    way_sel_i;
    logic          write_en_i;
    logic [7:0]    be_i;
    logic [49:0]   tag_in_i;
    logic [63:0]   wdata_i;
    logic [63:0]   rdata_selected_o;
    logic [49:0]   tag_selected_o;
    logic [1023:0] rdata_way_flat_o;
    logic [799:0]  tag_way_flat_o;

    rv64g_l2_arrays dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .index_i          (index_i),
        .word_sel_i       (word_sel_i),
        .way_sel_i        (way_sel_i),
        .write_en_i       (write_en_i),
        .be_i             (be_i),
        .tag_in_i         (tag_in_i),
        .wdata_i          (wdata_i),
        .rdata_selected_o (rdata_selected_o),
        .tag_selected_o   (tag_selected_o),
        .rdata_way_flat_o (rdata_way_flat_o),
        .tag_way_flat_o   (tag_way_flat_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  way;
        logic [63:0] data;
        logic [49:0] tag;
    } exp_t;

    exp_t        sb_q [$];
    logic [63:0] data_model [int];
    logic [49:0] tag_model  [int];
    int          checks_total  = 0;
    int          checks_passed = 0;

    task automatic checkOutput(input string name, input logic [1023:0] actual, input logic [1023:0] expected);
        checks_total++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end else begin
            checks_passed++;
        end
    endtask

    function automatic int dataKey(input logic [7:0] idx, input logic [3:0] way, input logic [2:0] word);
        return (int'(idx) << 7) | (int'(way) << 3) | int'(word);
    endfunction

    function automatic int tagKey(input logic [7:0] idx, input logic [3:0] way);
        return (int'(idx) << 4) | int'(way);
    endfunction

    // Drives one write cycle and mirrors its effect into the shadow model.
    task automatic applyStimulus(input logic [7:0] idx, input logic [2:0] word, input logic [3:0] way,
                                 input bit we, input logic [7:0] be, input logic [49:0] tag,
                                 input logic [63:0] data);
        int          dk;
        logic [63:0] d;
        @(negedge clk);
        index_i    = idx;
        word_sel_i = word;
        way_sel_i  = way;
        write_en_i = we;
        be_i       = be;
        tag_in_i   = tag;
        wdata_i    = data;
        if (we && rst_n) begin
            dk = dataKey(idx, way, word);
            d  = data_model.exists(dk) ? data_model[dk] : 64'bx;
            for (int k = 0; k < 8; k++) begin
                if (be[k]) d[8*k +: 8] = data[8*k +: 8];
            end
            data_model[dk] = d;
            tag_model[tagKey(idx, way)] = tag;
        end
        @(posedge clk);
        #1;
        write_en_i = 1'b0;
    endtask

    task automatic pushExpect(input string name, input logic [7:0] idx, input logic [2:0] word,
                              input logic [3:0] way);
        exp_t e;
        e.name = name;
        e.way  = way;
        e.data = data_model[dataKey(idx, way, word)];
        e.tag  = tag_model[tagKey(idx, way)];
        sb_q.push_back(e);
    endtask

    task automatic popCompare();
        exp_t e;
        if (sb_q.size() == 0) begin
            checkOutput("scoreboard_empty", 1'b0, 1'b1);
            return;
        end
        e = sb_q.pop_front();
        checkOutput({e.name, "_data_sel"}, rdata_selected_o, e.data);
        checkOutput({e.name, "_tag_sel"}, tag_selected_o, e.tag);
        checkOutput({e.name, "_data_flat"}, rdata_way_flat_o[e.way*64 +: 64], e.data);
        checkOutput({e.name, "_tag_flat"}, tag_way_flat_o[e.way*50 +: 50], e.tag);
    endtask

    task automatic doRead(input string name, input logic [7:0] idx, input logic [2:0] word,
                          input logic [3:0] way);
        write_en_i = 1'b0;
        index_i    = idx;
        word_sel_i = word;
        way_sel_i  = way;
        pushExpect(name, idx, word, way);
        #1;
        popCompare();
    endtask

    // Same-cycle read of the entry being written must show old contents, then new ones after the edge.
    task automatic readDuringWrite(input logic [7:0] idx, input logic [2:0] word, input logic [3:0] way,
                                   input logic [49:0] tag, input logic [63:0] data);
        @(negedge clk);
        index_i    = idx;
        word_sel_i = word;
        way_sel_i  = way;
        be_i       = 8'hFF;
        tag_in_i   = tag;
        wdata_i    = data;
        write_en_i = 1'b1;
        pushExpect("rdw_old", idx, word, way);
        #1;
        popCompare();
        data_model[dataKey(idx, way, word)] = data;
        tag_model[tagKey(idx, way)]         = tag;
        pushExpect("rdw_new", idx, word, way);
        @(posedge clk);
        #1;
        write_en_i = 1'b0;
        popCompare();
    endtask

    logic [7:0]  r_idx  [6];
    logic [2:0]  r_word [6];
    logic [3:0]  r_way  [6];

    initial begin
        rst_n      = 1'b0;
        index_i    = '0;
        word_sel_i = '0;
        way_sel_i  = '0;
        write_en_i = 1'b0;
        be_i       = '0;
        tag_in_i   = '0;
        wdata_i    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(8'h10, 3'd3, 4'd5, 1'b1, 8'hFF, 50'h3, 64'h3333_3333_3333_3333);
        applyStimulus(8'h11, 3'd2, 4'd5, 1'b1, 8'hFF, 50'h4, 64'h4444_4444_4444_4444);

        applyStimulus(8'h10, 3'd2, 4'd5, 1'b1, 8'hFF, 50'h123456789ABC, 64'hDEADBEEFCAFEBABE);
        doRead("full_write", 8'h10, 3'd2, 4'd5);
        checkOutput("full_write_const", rdata_selected_o, 64'hDEADBEEFCAFEBABE);

        applyStimulus(8'h10, 3'd2, 4'd6, 1'b1, 8'hFF, 50'h6, 64'h1);
        doRead("iso_way5", 8'h10, 3'd2, 4'd5);
        doRead("iso_way6", 8'h10, 3'd2, 4'd6);
        doRead("iso_word3", 8'h10, 3'd3, 4'd5);
        doRead("iso_idx11", 8'h11, 3'd2, 4'd5);

        applyStimulus(8'h10, 3'd2, 4'd5, 1'b1, 8'h0F, 50'h123456789ABC, 64'h0000000011111111);
        doRead("partial", 8'h10, 3'd2, 4'd5);
        checkOutput("partial_const", rdata_selected_o, 64'hDEADBEEF11111111);

        applyStimulus(8'h10, 3'd2, 4'd5, 1'b0, 8'hFF, 50'h0, 64'h0);
        doRead("we_low", 8'h10, 3'd2, 4'd5);

        applyStimulus(8'h10, 3'd2, 4'd5, 1'b1, 8'h00, 50'h0ABC, 64'hFFFF_FFFF_FFFF_FFFF);
        doRead("be_zero_tag", 8'h10, 3'd2, 4'd5);

        readDuringWrite(8'h11, 3'd2, 4'd5, 50'h5555, 64'h0123_4567_89AB_CDEF);

        applyStimulus(8'hFF, 3'd7, 4'd15, 1'b1, 8'hFF, {50{1'b1}}, 64'hA5A5_5A5A_F00D_0FF0);
        applyStimulus(8'h00, 3'd0, 4'd0, 1'b1, 8'hFF, 50'h1, 64'h0BAD_F00D_1234_5678);
        doRead("corner_max", 8'hFF, 3'd7, 4'd15);
        doRead("corner_min", 8'h00, 3'd0, 4'd0);

        for (int i = 0; i < 6; i++) begin
            r_idx[i]  = 8'($urandom_range(32, 250));
            r_word[i] = 3'($urandom);
            r_way[i]  = 4'($urandom);
            applyStimulus(r_idx[i], r_word[i], r_way[i], 1'b1, 8'hFF, 50'({$urandom, $urandom}),
                          {$urandom, $urandom});
        end
        for (int i = 0; i < 16; i++) begin
            int j;
            j = $urandom_range(0, 5);
            applyStimulus(r_idx[j], r_word[j], r_way[j], 1'b1, 8'($urandom), 50'({$urandom, $urandom}),
                          {$urandom, $urandom});
        end
        for (int i = 0; i < 6; i++) begin
            doRead($sformatf("rand%0d", i), r_idx[i], r_word[i], r_way[i]);
        end

        // Reset pulse: the write attempted while reset is held must be dropped.
        @(negedge clk);
        rst_n = 1'b0;
`ifdef RV64G_L2_ARRAYS_TAG_CLR_EN
        foreach (tag_model[k]) tag_model[k] = '0;
        index_i = 8'h10;
        #1;
        checkOutput("tag_clr_during_rst", tag_way_flat_o, 800'b0);
`endif
        applyStimulus(8'h10, 3'd2, 4'd5, 1'b1, 8'hFF, 50'h777, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        doRead("after_rst", 8'h10, 3'd2, 4'd5);
`ifdef RV64G_L2_ARRAYS_TAG_CLR_EN
        checkOutput("tag_clr_after_rst", tag_way_flat_o, 800'b0);
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: got no completion expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
